uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
- Boot-time loader sitting upstream of the fetch stage.
- Receives a program image over a UART serial line (8N1) and writes it word-by-word into instruction memory.
- Holds the pipeline in reset until the image is fully written.
- Drives the core's reset and the instruction-memory write port that the fetch stage reads from.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- ADDR_W, 10, instruction-memory word-address width; depth = 2^ADDR_W words.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  UART serial input, idle high, asynchronous to clk.
- imem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_rst  output  1  reset to the pipeline; high until load completes.
- load_done  output  1  high once the image is fully loaded.
- frame_err  output  1  sticky; set on any stop-bit error.

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, load_done=0, frame_err=0.
  - The 2-FF rx synchroniser resets to 1.
  - Both FSMs return to their first state.
  - Reset mid-load discards all partial state; the next load restarts at LEN0 / address 0.
- RX FSM (RX_IDLE, RX_START, RX_DATA, RX_STOP), operating on the synchronised rx:
  - RX_IDLE: arms only after seeing rx=1. An armed falling edge (rx=0) enters RX_START with the bit counter cleared.
  - RX_START: at CLKS_PER_BIT/2 (integer division) cycles, sample rx.
    - rx=1: glitch, return to RX_IDLE, no byte.
    - rx=0: enter RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - RX_STOP: sample after CLKS_PER_BIT cycles.
    - rx=1: byte_valid pulses for exactly 1 cycle with the byte.
    - rx=0: frame_err<=1 (sticky until rst), byte discarded.
    - Either way, return to RX_IDLE.
- Loader FSM (L_LEN0, L_LEN1, L_WORD, L_DONE), advancing only on byte_valid:
  - L_LEN0: byte -> count[7:0].
  - L_LEN1: byte -> count[15:8]. If the full count is 0, go to L_DONE; otherwise go to L_WORD with word_idx=0, byte_idx=0.
  - L_WORD: bytes assemble little-endian (byte_idx 0 -> bits 7:0 ... 3 -> bits 31:24).
    - On the cycle after the 4th byte's byte_valid: imem_we=1 for exactly 1 cycle, imem_addr=word_idx[ADDR_W-1:0], imem_wdata=assembled word.
    - Then word_idx increments and byte_idx returns to 0.
    - Words with word_idx >= 2^ADDR_W are consumed but not written (imem_we stays 0). The address never wraps.
    - When the incremented word_idx equals count, go to L_DONE.
  - L_DONE: load_done=1 and cpu_rst=0, both registered.
    - They change on the cycle after the final write pulse (T+1 if the write is at T); for count=0, the cycle after the LEN1 byte_valid.
    - All further bytes are ignored; rx errors still set frame_err.
    - Only rst leaves L_DONE.
- imem_addr and imem_wdata hold their last values between pulses.
- A byte in error never advances the loader; the host must resend it.
- The loader has no timeout.

Test Plan (bench uses CLKS_PER_BIT=4, ADDR_W=10 unless stated):
1. Reset: hold rst 3 cycles with rx=1 -> imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, load_done=0, frame_err=0; no output changes with rx idle for 200 cycles.
2. Two-word load: bytes 02 00 13 05 A0 00 93 05 10 00 -> exactly two imem_we pulses, addr 0 = 0x00A00513 and addr 1 = 0x00100593; cpu_rst falls and load_done rises exactly 1 cycle after the second pulse.
3. Zero length, then ignore: bytes 00 00 -> load_done=1 and cpu_rst=0 one cycle after the 2nd byte_valid, no imem_we. Then byte 0xFF -> no imem_we, outputs unchanged.
4. Errors: rx low for 1 cycle only -> no byte, loader unchanged. After header 01 00, send byte 0x13 with stop bit 0 -> frame_err=1, no advance. Then resend 13 05 A0 00 -> one write, addr 0 = 0x00A00513, load_done=1, frame_err stays 1.
5. Reset mid-load: send 02 00 13 05 A0, assert rst 1 cycle, then send full image 01 00 EF BE AD DE -> a single write, addr 0 = 0xDEADBEEF; no write from the pre-reset bytes.
6. Over-depth (ADDR_W=2): count=5 followed by 20 data bytes -> writes at addrs 0, 1, 2, 3 only; the 5th word is absorbed without imem_we; load_done rises 1 cycle after the 5th word's last byte_valid.

Source files
------------

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: streams a length-prefixed UART (8N1) program image into instruction memory,
// holding the pipeline in reset until every word of the image has been consumed.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {L_LEN0, L_LEN1, L_WORD, L_DONE} l_state_t;

    rx_state_t         rx_state_q;
    l_state_t          l_state_q;
    logic              rx_meta_q, rx_s_q, armed_q, byte_valid_q, frame_err_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q, byte_q;
    logic [15:0]       count_q, word_idx_q, nxt_idx_d;
    logic [1:0]        byte_idx_q;
    logic [23:0]       word_q;
    logic              we_q, cpu_rst_q, done_q, len_zero_d, in_range_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_state_q   <= RX_IDLE;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            byte_valid_q <= 1'b0;
            cnt_q        <= cnt_q + CW'(1);
            case (rx_state_q)
                RX_IDLE: begin
                    // a start edge only counts once the line has been seen idle-high
                    armed_q <= armed_q | rx_s_q;
                    if (armed_q && !rx_s_q) begin
                        rx_state_q <= RX_START;
                        cnt_q      <= '0;
                        bit_q      <= '0;
                    end
                end
                RX_START: if (cnt_q == HALF) begin
                    cnt_q      <= '0;
                    armed_q    <= 1'b0;
                    rx_state_q <= rx_s_q ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (cnt_q == FULL) begin
                    cnt_q   <= '0;
                    shift_q <= {rx_s_q, shift_q[7:1]};
                    bit_q   <= bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_q <= RX_STOP;
                end
                RX_STOP: if (cnt_q == FULL) begin
                    rx_state_q <= RX_IDLE;
                    if (rx_s_q) begin
                        byte_q       <= shift_q;
                        byte_valid_q <= 1'b1;
                    end else begin
                        frame_err_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        len_zero_d = {byte_q, count_q[7:0]} == 16'd0;
        in_range_d = (word_idx_q >> ADDR_W) == 16'd0;
        nxt_idx_d  = word_idx_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_state_q  <= L_LEN0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (l_state_q == L_DONE) begin
                done_q    <= 1'b1;
                cpu_rst_q <= 1'b0;
            end
            if (byte_valid_q) begin
                case (l_state_q)
                    L_LEN0: begin
                        count_q[7:0] <= byte_q;
                        l_state_q    <= L_LEN1;
                    end
                    L_LEN1: begin
                        count_q[15:8] <= byte_q;
                        word_idx_q    <= '0;
                        byte_idx_q    <= '0;
                        l_state_q     <= len_zero_d ? L_DONE : L_WORD;
                        done_q        <= len_zero_d;
                        cpu_rst_q     <= !len_zero_d;
                    end
                    L_WORD: begin
                        word_q     <= {byte_q, word_q[23:8]};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            word_idx_q <= nxt_idx_d;
                            we_q       <= in_range_d;
                            if (in_range_d) begin
                                addr_q  <= word_idx_q[ADDR_W-1:0];
                                wdata_q <= {byte_q, word_q};
                            end
                            // with no write pulse to wait behind, release the core right away
                            if (nxt_idx_d == count_q) begin
                                l_state_q <= L_DONE;
                                done_q    <= !in_range_d;
                                cpu_rst_q <= in_range_d;
                            end
                        end
                    end
                    L_DONE: ;
                endcase
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign load_done  = done_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: scoreboard bench; stimulus queues expected writes, a negedge monitor pops them.
module tb_uart_imem_loader;
    localparam int CPB = 4;

    logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, rst2 = 1'b1, rx2 = 1'b1;
    logic        we0, cr0, ld0, fe0, we1, cr1, ld1, fe1;
    logic [9:0]  ad0;
    logic [1:0]  ad1;
    logic [31:0] wd0, wd1;

    always #5 clk = ~clk;

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(10)) u0 (
        .clk(clk), .rst(rst), .rx(rx), .imem_we(we0), .imem_addr(ad0), .imem_wdata(wd0),
        .cpu_rst(cr0), .load_done(ld0), .frame_err(fe0)
    );
    uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) u1 (
        .clk(clk), .rst(rst2), .rx(rx2), .imem_we(we1), .imem_addr(ad1), .imem_wdata(wd1),
        .cpu_rst(cr1), .load_done(ld1), .frame_err(fe1)
    );

    int          n_cmp = 0, n_bad = 0, cyc = 0;
    logic [63:0] q0[$], q1[$];
    int          we_cyc[2], bv_cyc[2];
    bit          done_prev[2], bv_mode[2];

    function automatic void check(string n, logic [63:0] a, logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", n, a, e);
        end
    endfunction

    function automatic void mon(int i, logic we, logic [31:0] ad, logic [31:0] wd, logic ld, logic cr, logic bv);
        logic [63:0] e;
        if (bv) bv_cyc[i] = cyc;
        if (we) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL u%0d_unexpected_write: got addr %0h data %0h, expected no write", i, ad, wd);
            end else begin
                if (i == 0) e = q0.pop_front();
                else e = q1.pop_front();
                check($sformatf("u%0d_write_addr", i), 64'(ad), 64'(e[63:32]));
                check($sformatf("u%0d_write_data", i), 64'(wd), 64'(e[31:0]));
            end
            we_cyc[i] = cyc;
        end
        if (ld && !done_prev[i]) begin
            check($sformatf("u%0d_done_latency", i), 64'(cyc - (bv_mode[i] ? bv_cyc[i] : we_cyc[i])), 64'd1);
            check($sformatf("u%0d_cpu_rst_at_done", i), 64'(cr), 64'd0);
        end
        done_prev[i] = ld;
    endfunction

    always @(negedge clk) begin
        cyc++;
        mon(0, we0, 32'(ad0), wd0, ld0, cr0, u0.byte_valid_q);
        mon(1, we1, 32'(ad1), wd1, ld1, cr1, u1.byte_valid_q);
    end

    task automatic send(input int i, input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            if (i == 0) rx = f[k];
            else rx2 = f[k];
            repeat (CPB) @(negedge clk);
        end
        if (i == 0) rx = 1'b1;
        else rx2 = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_all(input int i, input logic [7:0] bs[$]);
        foreach (bs[k]) send(i, bs[k], 1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rst2 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rst2 = 1'b0;
    endtask

    initial begin
        bit stable;
        // 1: reset state and idle stability
        do_reset();
        check("rst_we", 64'(we0), 64'd0);
        check("rst_addr", 64'(ad0), 64'd0);
        check("rst_wdata", 64'(wd0), 64'd0);
        check("rst_cpu_rst", 64'(cr0), 64'd1);
        check("rst_load_done", 64'(ld0), 64'd0);
        check("rst_frame_err", 64'(fe0), 64'd0);
        stable = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (we0 || ad0 != 0 || wd0 != 0 || !cr0 || ld0 || fe0) stable = 1'b0;
        end
        check("idle_stable", 64'(stable), 64'd1);

        // 2: two-word load
        do_reset();
        bv_mode[0] = 1'b0;
        q0.push_back({32'd0, 32'h00A00513});
        q0.push_back({32'd1, 32'h00100593});
        send_all(0, '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00});
        check("two_word_done", 64'(ld0), 64'd1);
        check("two_word_cpu_rst", 64'(cr0), 64'd0);
        check("two_word_missing_writes", 64'(q0.size()), 64'd0);

        // 3: zero length, then a byte that must be ignored
        do_reset();
        bv_mode[0] = 1'b1;
        send_all(0, '{8'h00, 8'h00});
        check("zero_len_done", 64'(ld0), 64'd1);
        check("zero_len_cpu_rst", 64'(cr0), 64'd0);
        send_all(0, '{8'hFF});
        check("ignored_done", 64'(ld0), 64'd1);
        check("ignored_cpu_rst", 64'(cr0), 64'd0);
        check("ignored_addr", 64'(ad0), 64'd0);
        check("ignored_wdata", 64'(wd0), 64'd0);

        // 4: glitch, framing error, resend
        do_reset();
        bv_mode[0] = 1'b0;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_frame_err", 64'(fe0), 64'd0);
        send_all(0, '{8'h01, 8'h00});
        send(0, 8'h13, 1'b0);
        repeat (10) @(negedge clk);
        check("stop_err_frame_err", 64'(fe0), 64'd1);
        check("stop_err_not_done", 64'(ld0), 64'd0);
        q0.push_back({32'd0, 32'h00A00513});
        send_all(0, '{8'h13, 8'h05, 8'hA0, 8'h00});
        check("resend_done", 64'(ld0), 64'd1);
        check("resend_frame_err_sticky", 64'(fe0), 64'd1);
        check("resend_missing_write", 64'(q0.size()), 64'd0);

        // 5: reset in the middle of a load
        do_reset();
        send_all(0, '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_not_done", 64'(ld0), 64'd0);
        q0.push_back({32'd0, 32'hDEADBEEF});
        send_all(0, '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        check("midrst_done", 64'(ld0), 64'd1);
        check("midrst_missing_write", 64'(q0.size()), 64'd0);

        // 6: image longer than a 4-word memory
        do_reset();
        bv_mode[1] = 1'b1;
        for (int k = 0; k < 4; k++) q1.push_back({32'(k), {4{8'((k + 1) * 17)}}});
        send(1, 8'h05, 1'b1);
        send(1, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) repeat (4) send(1, 8'((k + 1) * 17), 1'b1);
        repeat (10) @(negedge clk);
        check("overdepth_done", 64'(ld1), 64'd1);
        check("overdepth_cpu_rst", 64'(cr1), 64'd0);
        check("overdepth_missing_writes", 64'(q1.size()), 64'd0);
        check("overdepth_last_addr", 64'(ad1), 64'd3);
        check("overdepth_last_wdata", 64'(wd1), 64'h44444444);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
